// File: rtl/geig_stack_pkg.sv
// Shared types and constants for the Geiger sample stack harness.
// Word/byte sizing, sync marker, serializer state enum, byte helper.
package geig_stack_pkg;

  localparam int WORD_W = 48;
  localparam int BYTES_PER_WORD = 6;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SYNC,
    S_BYTE
  } ser_state_t;

  // idx 5 selects [47:40], idx 0 selects [7:0]
  function automatic logic [7:0] byte_of(word_t w, logic [2:0] idx);
    return 8'(w >> {idx, 3'b000});
  endfunction

endpackage

// File: rtl/geig_stack_if.sv
// Push/pop bundle between the harness and its word stack.
// master: push, pop, wdata out; rdata, full, empty in. slave: reverse.
interface geig_stack_if;
  import geig_stack_pkg::*;

  logic  push;
  logic  pop;
  word_t wdata;
  word_t rdata;
  logic  full;
  logic  empty;

  modport master (
    output push, pop, wdata,
    input  rdata, full, empty
  );

  modport slave (
    input  push, pop, wdata,
    output rdata, full, empty
  );

endinterface

// File: rtl/geig_word_stack.sv
// FIFO-ordered word store, DEPTH words (power of two), head on rdata.
// Ports: clk, rst_n (async, low), st (slave: push/pop/wdata/rdata/full/empty).
module geig_word_stack
  import geig_stack_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst_n,
  geig_stack_if.slave st
);

  localparam int AW = $clog2(DEPTH);

  word_t         mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_pop;
  logic          do_push;

  assign st.empty = (cnt == '0);
  assign st.full  = (cnt == (AW+1)'(DEPTH));
  assign st.rdata = mem[rd_ptr];

  // a full stack still takes a word if one leaves on the same edge
  assign do_pop  = st.pop && !st.empty;
  assign do_push = st.push && (!st.full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= st.wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/test_harness_geiger_stack.sv
// Samples TEST_DATA every SAMPLE_PERIOD clocks into a word stack and
// serializes each word as a byte frame on D7..D0 (00 when idle).
// Ports: CLK_1MHZ, NSYSRESET (async, low), TEST_DATA[47:0], D0..D7.
// Build macro GEIG_FRAME_SYNC_EN: prefix each frame with an A5 byte.
module test_harness_geiger_stack
  import geig_stack_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 20,
  parameter int DEPTH = 8
) (
  input  logic        CLK_1MHZ,
  input  logic        NSYSRESET,
  input  logic [47:0] TEST_DATA,
  output logic        D0,
  output logic        D1,
  output logic        D2,
  output logic        D3,
  output logic        D4,
  output logic        D5,
  output logic        D6,
  output logic        D7
);

  localparam logic [2:0] FIRST_IDX = 3'(BYTES_PER_WORD - 1);

`ifdef GEIG_FRAME_SYNC_EN
  localparam ser_state_t START = S_SYNC;
`else
  localparam ser_state_t START = S_BYTE;
`endif

  geig_stack_if st ();

  geig_word_stack #(
    .DEPTH (DEPTH)
  ) u_stack (
    .clk   (CLK_1MHZ),
    .rst_n (NSYSRESET),
    .st    (st)
  );

  logic [15:0] smp_cnt;
  logic        tick;

  assign tick = (smp_cnt == 16'(SAMPLE_PERIOD - 1));

  always_ff @(posedge CLK_1MHZ or negedge NSYSRESET) begin
    if (!NSYSRESET) smp_cnt <= '0;
    else            smp_cnt <= tick ? '0 : smp_cnt + 1'b1;
  end

  assign st.push  = tick;
  assign st.wdata = TEST_DATA;

  ser_state_t state, nstate;
  logic [2:0] idx, nidx;
  word_t      word, word_next;
  logic [7:0] d_q, d_next;
  logic       last;

  // state/idx describe the byte currently on D
  assign last   = (state == S_BYTE) && (idx == '0);
  assign st.pop = ((state == S_IDLE) || last) && !st.empty;

  always_ff @(posedge CLK_1MHZ or negedge NSYSRESET) begin
    if (!NSYSRESET) begin
      state <= S_IDLE;
      idx   <= '0;
      word  <= '0;
      d_q   <= '0;
    end else begin
      state <= nstate;
      idx   <= nidx;
      word  <= word_next;
      d_q   <= d_next;
    end
  end

  always_comb begin
    nstate = state;
    nidx   = idx;
    unique case (state)
      S_SYNC: begin
        nstate = S_BYTE;
        nidx   = FIRST_IDX;
      end
      S_BYTE: begin
        if (idx != '0) nidx = idx - 1'b1;
        else           nstate = S_IDLE;
      end
      default: ;
    endcase
    if (st.pop) begin
      nstate = START;
      nidx   = FIRST_IDX;
    end
  end

  always_comb begin
    word_next = st.pop ? st.rdata : word;
    d_next    = '0;
    unique case (nstate)
      S_SYNC:  d_next = SYNC_BYTE;
      S_BYTE:  d_next = byte_of(word_next, nidx);
      default: d_next = '0;
    endcase
  end

  assign {D7, D6, D5, D4, D3, D2, D1, D0} = d_q;

endmodule

// File: tb/tb_test_harness_geiger_stack.sv
// Randomized bench for test_harness_geiger_stack: two instances
// (period 20 and period 1) checked against a queue-level model.
module tb_test_harness_geiger_stack;

  localparam int P0  = 20;
  localparam int P1  = 1;
  localparam int DEP = 8;
`ifdef GEIG_FRAME_SYNC_EN
  localparam int FLEN = 7;
  localparam bit HAS_SYNC = 1'b1;
`else
  localparam int FLEN = 6;
  localparam bit HAS_SYNC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [47:0] td0, td1;
  wire  [7:0]  q0, q1;

  int vectors = 0;
  int miscompares = 0;
  logic [47:0] cyc;

  always #5 clk = ~clk;

  test_harness_geiger_stack #(
    .SAMPLE_PERIOD (P0),
    .DEPTH         (DEP)
  ) dut0 (
    .CLK_1MHZ  (clk),
    .NSYSRESET (rst_n),
    .TEST_DATA (td0),
    .D0 (q0[0]), .D1 (q0[1]), .D2 (q0[2]), .D3 (q0[3]),
    .D4 (q0[4]), .D5 (q0[5]), .D6 (q0[6]), .D7 (q0[7])
  );

  test_harness_geiger_stack #(
    .SAMPLE_PERIOD (P1),
    .DEPTH         (DEP)
  ) dut1 (
    .CLK_1MHZ  (clk),
    .NSYSRESET (rst_n),
    .TEST_DATA (td1),
    .D0 (q1[0]), .D1 (q1[1]), .D2 (q1[2]), .D3 (q1[3]),
    .D4 (q1[4]), .D5 (q1[5]), .D6 (q1[6]), .D7 (q1[7])
  );

  // model: bounded word queue + frame currently being sent
  logic [47:0] mq [2][DEP];
  int mhead [2];
  int mcnt [2];
  int left [2];
  int ecnt [2];
  logic [47:0] cur [2];

  task automatic check(string tag, logic [47:0] got, logic [47:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      mhead[i] = 0;
      mcnt[i]  = 0;
      left[i]  = 0;
      ecnt[i]  = 0;
    end
  endtask

  task automatic model_step(int i, logic [47:0] din, output logic [7:0] exp);
    int per;
    int k;
    per = (i == 0) ? P0 : P1;
    ecnt[i]++;
    exp = 8'h00;
    if (left[i] == 0 && mcnt[i] > 0) begin
      cur[i]   = mq[i][mhead[i]];
      mhead[i] = (mhead[i] + 1) % DEP;
      mcnt[i]--;
      left[i]  = FLEN;
    end
    if (left[i] > 0) begin
      k = FLEN - left[i];
      if (HAS_SYNC) exp = (k == 0) ? 8'hA5 : 8'(cur[i] >> (8 * (6 - k)));
      else          exp = 8'(cur[i] >> (8 * (5 - k)));
      left[i]--;
    end
    if (ecnt[i] % per == 0 && mcnt[i] < DEP) begin
      mq[i][(mhead[i] + mcnt[i]) % DEP] = din;
      mcnt[i]++;
    end
  endtask

  task automatic step();
    logic [7:0] e0, e1;
    @(posedge clk);
    model_step(0, td0, e0);
    model_step(1, td1, e1);
    #1;
    check("d_p20", q0, e0);
    check("d_p1", q1, e1);
    @(negedge clk);
    cyc = cyc + 1;
    td1 = cyc;
  endtask

  logic [7:0] tbl [7];
  logic       hit;

  initial begin
    if (HAS_SYNC) begin
      tbl[0] = 8'hA5; tbl[1] = 8'h00; tbl[2] = 8'h00; tbl[3] = 8'h00;
      tbl[4] = 8'h00; tbl[5] = 8'h27; tbl[6] = 8'h10;
    end else begin
      tbl[0] = 8'h00; tbl[1] = 8'h00; tbl[2] = 8'h00; tbl[3] = 8'h00;
      tbl[4] = 8'h27; tbl[5] = 8'h10; tbl[6] = 8'h00;
    end
    cyc   = '0;
    rst_n = 1'b0;
    td0   = '0;
    td1   = '0;
    model_reset();
    repeat (10) begin
      @(posedge clk);
      #1;
      check("rst_p20", q0, 8'h00);
      check("rst_p1", q1, 8'h00);
    end
    @(negedge clk);
    rst_n = 1'b1;

    // constant 10000: first frame on edges 21..27
    td0 = 48'd10000;
    for (int n = 1; n <= 40; n++) begin
      step();
      if (n >= 21 && n <= 27) check("first_frame", q0, tbl[n - 21]);
    end

    // ramp by 1000 per sample period
    for (int m = 1; m <= 10; m++) begin
      td0 = 48'd10000 + 48'(1000 * m);
      repeat (P0) step();
    end

    // random sample words
    for (int n = 0; n < 300; n++) begin
      td0 = {16'($urandom), $urandom};
      step();
    end

    // reset while the third data byte is on the bus
    hit = 1'b0;
    for (int n = 0; n < 200 && !hit; n++) begin
      step();
      if (left[0] == 3) hit = 1'b1;
    end
    check("wait_3rd_byte", 48'(hit), 48'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_p20", q0, 8'h00);
    check("async_rst_p1", q1, 8'h00);
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 300; n++) begin
      td0 = {16'($urandom), $urandom};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
